lcd_bus_driver: RTL
===================

// Module: lcd_bus_driver
// PURPOSE
//  Physical-bus stage downstream of the LCD sequencing FSM. Accepts one byte (command or
//  data) per valid/ready handshake, drives an HD44780-style write cycle (setup, enable
//  pulse, hold), then waits the controller execution time before accepting the next byte.
//  Owns lcd_data/lcd_rs/lcd_rw/lcd_en pins; upstream never drives them directly.
// PARAMETERS
//  SETUP_CYC      4      clocks rs/data stable before lcd_en rises (>=1)
//  EN_HIGH_CYC    12     clocks lcd_en held high (>=1)
//  HOLD_CYC       2      clocks rs/data held after lcd_en falls (>=1)
//  EXEC_CYC       2000   wait after a normal command/data byte (40 us @ 50 MHz)
//  LONG_EXEC_CYC  82000  wait after clear/home commands (1.64 ms @ 50 MHz)
// PORTS
//  clk        in   1  system clock, rising edge
//  reset      in   1  asynchronous, active-high
//  in_valid   in   1  upstream has a byte
//  in_ready   out  1  driver can accept a byte
//  in_rs      in   1  0 = command, 1 = character data
//  in_data    in   8  byte to write
//  lcd_data   out  8  LCD data bus
//  lcd_rs     out  1  LCD register select
//  lcd_rw     out  1  LCD read/write; constant 0 (write-only driver)
//  lcd_en     out  1  LCD enable strobe
//  cmd_done   out  1  one-cycle pulse when the execution wait of a byte ends
// BEHAVIOUR
//  Reset: lcd_data=0, lcd_rs=0, lcd_rw=0, lcd_en=0, cmd_done=0, in_ready=0, state=IDLE.
//   in_ready rises on first clk edge after reset deasserts. Reset mid-transfer drops
//   lcd_en immediately and discards the byte; no cmd_done is produced for it.
//  All outputs registered. States: IDLE -> SETUP -> PULSE -> HOLD -> EXEC -> IDLE.
//  IDLE: in_ready=1; accept on edge where in_valid&&in_ready; latch in_rs/in_data, drive
//   lcd_rs/lcd_data from that edge, in_ready=0, go SETUP. in_valid without ready: no effect.
//  SETUP: SETUP_CYC clocks, lcd_en=0. PULSE: EN_HIGH_CYC clocks, lcd_en=1.
//  HOLD: HOLD_CYC clocks, lcd_en=0, rs/data unchanged. EXEC: wait count, bus stable.
//  Long wait: in_rs==0 && in_data[7:2]==0 && in_data[1:0]!=0 (0x01..0x03) uses
//   LONG_EXEC_CYC; every other byte (incl. 0x00, all rs=1) uses EXEC_CYC.
//  EXEC exit edge: cmd_done=1 for one clock, in_ready=1 on same edge, state IDLE.
//  Accept-to-lcd_en-rise = SETUP_CYC clocks; accept-to-in_ready =
//   SETUP_CYC+EN_HIGH_CYC+HOLD_CYC+exec clocks (8-bit mode).
//  Back-to-back: byte offered while cmd_done is high is accepted on the next edge.
//  Phase counter width = $clog2(LONG_EXEC_CYC+1); loaded with (N-1), counts to 0.
// CONFIGURATION
//  LCD_4BIT_EN defined: 4-bit interface. Byte sent as two nibbles on lcd_data[7:4], high
//   nibble first, lcd_data[3:0]=0. SETUP/PULSE/HOLD run twice (nibble flag), EXEC once,
//   after the low nibble. rs stable across both nibbles. Latency adds
//   SETUP_CYC+EN_HIGH_CYC+HOLD_CYC.
//  LCD_4BIT_EN undefined: 8-bit interface, single strobe per byte as above.
// STRUCTURE
//  Package lcd_pkg: command constants (CLEAR_DISPLAY 8'h01, HOME 8'h02, ENTRY_MODE_SET
//   8'h06, DISPLAY_ON 8'h0C, CURSOR_LEFT 8'h10, CURSOR_RIGHT 8'h14), driver state
//   encoding, default timing constants shared with the sequencing FSM.
//  Sub-module lcd_phase_timer: loadable down-counter with zero flag, one instance.
// TESTING
//  Reset release, in_valid=0 -> in_ready=1 one edge later, all pins 0, no cmd_done.
//  rs=1 data 0x57 ('W') -> lcd_en high exactly clocks 4..15 after accept, data 0x57,
//   rs=1 throughout, cmd_done 2018 clocks after accept.
//  rs=0 data 0x01 -> cmd_done after 4+12+2+82000 clocks; 0x06 -> after 2018 clocks.
//  in_valid held high with 7 bytes "WASHING" -> 7 strobes in order, no drop/duplicate,
//   in_ready low throughout each transfer.
//  reset asserted during PULSE -> lcd_en=0 same cycle, no cmd_done, next byte clean.
//  LCD_4BIT_EN: rs=1 0x41 -> nibbles 0x4 then 0x1 on lcd_data[7:4], two strobes, one
//   cmd_done.

Source files
------------

// File: rtl/lcd_bus_driver_pkg.sv
// Shared definitions for the LCD bus driver and its sequencing FSM.
// Holds HD44780 command codes, default write-cycle timing and driver state encoding.
// Also provides the long-execution command classifier.
package lcd_pkg;

  // HD44780 command bytes used by the sequencing FSM
  localparam logic [7:0] CLEAR_DISPLAY  = 8'h01;
  localparam logic [7:0] HOME           = 8'h02;
  localparam logic [7:0] ENTRY_MODE_SET = 8'h06;
  localparam logic [7:0] DISPLAY_ON     = 8'h0C;
  localparam logic [7:0] CURSOR_LEFT    = 8'h10;
  localparam logic [7:0] CURSOR_RIGHT   = 8'h14;

  // Default write-cycle timing in clk cycles at 50 MHz
  localparam int DEF_SETUP_CYC     = 4;
  localparam int DEF_EN_HIGH_CYC   = 12;
  localparam int DEF_HOLD_CYC      = 2;
  localparam int DEF_EXEC_CYC      = 2000;
  localparam int DEF_LONG_EXEC_CYC = 82000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_EXEC
  } drv_state_t;

  // Clear (0x01) and home (0x02/0x03) commands need the long controller wait
  function automatic logic needs_long_exec(input logic rs, input logic [7:0] data);
    return !rs && (data[7:2] == 6'd0) && (data[1:0] != 2'd0);
  endfunction

endpackage

// File: rtl/lcd_bus_driver_if.sv
// Byte handshake between the sequencing FSM (master) and the bus driver (slave).
// A byte moves on a clock edge where in_valid and in_ready are both high.
// in_rs selects command (0) or character data (1).
interface lcd_bus_driver_if;
  logic       in_valid;
  logic       in_ready;
  logic       in_rs;
  logic [7:0] in_data;

  modport master (output in_valid, output in_rs, output in_data, input in_ready);
  modport slave  (input in_valid, input in_rs, input in_data, output in_ready);
endinterface

// File: rtl/lcd_bus_driver_phase_timer.sv
// Loadable down-counter timing each write-cycle phase; zero flag marks the last cycle.
// Load takes effect on the next edge; counter then decrements to 0 and stays there.
// A phase of N cycles is timed by loading N-1.
module lcd_phase_timer #(
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic             zero
);

  logic [WIDTH-1:0] cnt;

  // Load a new phase length or count the current one down to zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/lcd_bus_driver.sv
// HD44780 write-cycle driver: accepts a byte, strobes it onto the LCD pins, waits exec time.
// Accept-to-lcd_en-rise SETUP_CYC clocks; in_ready returns after setup+pulse+hold+exec.
// in_ready is low for the whole transfer; LCD_4BIT_EN selects the two-nibble 4-bit bus.
module lcd_bus_driver
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC     = DEF_SETUP_CYC,
  parameter int EN_HIGH_CYC   = DEF_EN_HIGH_CYC,
  parameter int HOLD_CYC      = DEF_HOLD_CYC,
  parameter int EXEC_CYC      = DEF_EXEC_CYC,
  parameter int LONG_EXEC_CYC = DEF_LONG_EXEC_CYC
) (
  input  logic              clk,
  input  logic              reset,
  lcd_bus_driver_if.slave   up,
  output logic [7:0]        lcd_data,
  output logic              lcd_rs,
  output logic              lcd_rw,
  output logic              lcd_en,
  output logic              cmd_done
);

  localparam int CW = $clog2(LONG_EXEC_CYC + 1);
  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] EN_LD    = CW'(EN_HIGH_CYC - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] EXEC_LD  = CW'(EXEC_CYC - 1);
  localparam logic [CW-1:0] LONG_LD  = CW'(LONG_EXEC_CYC - 1);

  drv_state_t    state;
  logic          in_ready_q;
  logic          long_q;
  logic          accept;
  logic          tmr_load;
  logic [CW-1:0] tmr_val;
  logic          tmr_zero;
`ifdef LCD_4BIT_EN
  logic          nib_q;      // 0 while the high nibble is on the bus
  logic [3:0]    lo_nib_q;
`endif

  assign accept      = (state == ST_IDLE) && in_ready_q && up.in_valid;
  assign up.in_ready = in_ready_q;
  assign lcd_rw      = 1'b0;

  // Start the next phase's count on the edge that leaves the current phase
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          tmr_load = 1'b1;
          tmr_val  = SETUP_LD;
        end
      end
      ST_SETUP: begin
        if (tmr_zero) begin
          tmr_load = 1'b1;
          tmr_val  = EN_LD;
        end
      end
      ST_PULSE: begin
        if (tmr_zero) begin
          tmr_load = 1'b1;
          tmr_val  = HOLD_LD;
        end
      end
      ST_HOLD: begin
        if (tmr_zero) begin
          tmr_load = 1'b1;
`ifdef LCD_4BIT_EN
          if (!nib_q) tmr_val = SETUP_LD;
          else        tmr_val = long_q ? LONG_LD : EXEC_LD;
`else
          tmr_val  = long_q ? LONG_LD : EXEC_LD;
`endif
        end
      end
      default: ;
    endcase
  end

  lcd_phase_timer #(.WIDTH(CW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // Write-cycle sequencer; all pins and the handshake are registered here
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      in_ready_q <= 1'b0;
      lcd_data   <= 8'h00;
      lcd_rs     <= 1'b0;
      lcd_en     <= 1'b0;
      cmd_done   <= 1'b0;
      long_q     <= 1'b0;
`ifdef LCD_4BIT_EN
      nib_q      <= 1'b0;
      lo_nib_q   <= 4'h0;
`endif
    end else begin
      cmd_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            in_ready_q <= 1'b0;
            lcd_rs     <= up.in_rs;
            long_q     <= needs_long_exec(up.in_rs, up.in_data);
`ifdef LCD_4BIT_EN
            lcd_data   <= {up.in_data[7:4], 4'h0};
            lo_nib_q   <= up.in_data[3:0];
            nib_q      <= 1'b0;
`else
            lcd_data   <= up.in_data;
`endif
            state      <= ST_SETUP;
          end else begin
            in_ready_q <= 1'b1;
          end
        end
        ST_SETUP: begin
          if (tmr_zero) begin
            lcd_en <= 1'b1;
            state  <= ST_PULSE;
          end
        end
        ST_PULSE: begin
          if (tmr_zero) begin
            lcd_en <= 1'b0;
            state  <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (tmr_zero) begin
`ifdef LCD_4BIT_EN
            if (!nib_q) begin
              nib_q    <= 1'b1;
              lcd_data <= {lo_nib_q, 4'h0};
              state    <= ST_SETUP;
            end else begin
              state    <= ST_EXEC;
            end
`else
            state <= ST_EXEC;
`endif
          end
        end
        ST_EXEC: begin
          if (tmr_zero) begin
            cmd_done   <= 1'b1;
            in_ready_q <= 1'b1;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
